// File: rtl/lcd_expr_writer.sv
// lcd_expr_writer
//   Writes the expression "a op b = rr" to line 1 of a character LCD. One
//   iGO request starts the sequence. The request snapshots the operands, the
//   operator and the ALU result. The sequence clears the screen and then sends
//   one byte per driver transaction. A fixed settle delay of DLY_MAX+1 cycles
//   follows each transaction.
//
// Ports
//   iCLK        system clock
//   iRST        synchronous reset, active-high
//   iGO         write request, accepted only while idle
//   iA, iB      operand digits (values above 9 are shown as '?')
//   iOP         operator select: 0 '+', 1 '-', 2 '*', 3 '/'
//   iRES        ALU result (values above 99 are shown as "EE")
//   oBUSY       high from the accepted request until the return to idle
//   oDONE       one-cycle pulse when the last byte has settled
//   oLCD_DATA   byte to the LCD driver
//   oLCD_RS     0 = command, 1 = character
//   oLCD_START  transaction request to the LCD driver
//   iLCD_DONE   transaction completion from the LCD driver

module lcd_expr_writer #(
   parameter int unsigned DLY_MAX = 18'h3FFFE,
   parameter int unsigned DLY_W   = 18
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iGO,
   input  logic [3:0] iA,
   input  logic [3:0] iB,
   input  logic [1:0] iOP,
   input  logic [7:0] iRES,
   output logic       oBUSY,
   output logic       oDONE,
   output logic [7:0] oLCD_DATA,
   output logic       oLCD_RS,
   output logic       oLCD_START,
   input  logic       iLCD_DONE
);

   // state | meaning
   // IDLE  | waiting for iGO
   // SEND  | load the byte for idx and raise oLCD_START
   // WAIT  | hold the request until the driver reports done
   // DELAY | settle for DLY_MAX+1 cycles, then next byte or finish
   typedef enum logic [1:0] {IDLE, SEND, WAIT, DELAY} state_t;

   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_MAX);

   state_t           state;
   logic [3:0]       snap_a;
   logic [3:0]       snap_b;
   logic [1:0]       snap_op;
   logic [7:0]       snap_res;
   logic [2:0]       idx;
   logic [DLY_W-1:0] dly_cnt;

   logic [7:0] res_tens;
   logic [7:0] res_ones;
   logic [7:0] tens_char;
   logic [7:0] ones_char;
   logic [7:0] op_char;
   logic [7:0] byte_data;
   logic       byte_rs;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      if (d > 4'd9) return 8'h3F;
      return 8'h30 + {4'h0, d};
   endfunction

   always_comb begin
      res_tens  = snap_res / 8'd10;
      res_ones  = snap_res % 8'd10;
      tens_char = 8'h45;
      ones_char = 8'h45;
      if (snap_res <= 8'd99) begin
         // A leading zero is blanked so single-digit results stay right-aligned.
         tens_char = (res_tens == 8'd0) ? 8'h20 : 8'h30 + res_tens;
         ones_char = 8'h30 + res_ones;
      end

      case (snap_op)
         2'd0:    op_char = 8'h2B;
         2'd1:    op_char = 8'h2D;
         2'd2:    op_char = 8'h2A;
         default: op_char = 8'h2F;
      endcase

      byte_rs = 1'b1;
      case (idx)
         3'd0: begin
            byte_rs   = 1'b0;
            byte_data = 8'h01;
         end
         3'd1:    byte_data = digit_char(snap_a);
         3'd2:    byte_data = op_char;
         3'd3:    byte_data = digit_char(snap_b);
         3'd4:    byte_data = 8'h3D;
         3'd5:    byte_data = tens_char;
         3'd6:    byte_data = ones_char;
         default: byte_data = 8'h00;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state      <= IDLE;
         snap_a     <= '0;
         snap_b     <= '0;
         snap_op    <= '0;
         snap_res   <= '0;
         idx        <= '0;
         dly_cnt    <= '0;
         oBUSY      <= 1'b0;
         oDONE      <= 1'b0;
         oLCD_DATA  <= 8'h00;
         oLCD_RS    <= 1'b0;
         oLCD_START <= 1'b0;
      end else begin
         oDONE <= 1'b0;
         case (state)
            IDLE: begin
               if (iGO) begin
                  snap_a   <= iA;
                  snap_b   <= iB;
                  snap_op  <= iOP;
                  snap_res <= iRES;
                  idx      <= '0;
                  oBUSY    <= 1'b1;
                  state    <= SEND;
               end
            end
            SEND: begin
               oLCD_DATA  <= byte_data;
               oLCD_RS    <= byte_rs;
               oLCD_START <= 1'b1;
               state      <= WAIT;
            end
            WAIT: begin
               if (iLCD_DONE) begin
                  oLCD_START <= 1'b0;
                  dly_cnt    <= '0;
                  state      <= DELAY;
               end
            end
            DELAY: begin
               if (dly_cnt == DLY_LAST) begin
                  if (idx != 3'd6) begin
                     idx   <= idx + 3'd1;
                     state <= SEND;
                  end else begin
                     oBUSY <= 1'b0;
                     oDONE <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  dly_cnt <= dly_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_expr_writer.sv
module tb_lcd_expr_writer;

   localparam int DLY_MAX = 3;

   typedef logic [8:0] seq_t [7];

   logic       iCLK = 1'b0;
   logic       iRST = 1'b1;
   logic       iGO = 1'b1;
   logic [3:0] iA = '0;
   logic [3:0] iB = '0;
   logic [1:0] iOP = '0;
   logic [7:0] iRES = '0;
   logic       oBUSY;
   logic       oDONE;
   logic [7:0] oLCD_DATA;
   logic       oLCD_RS;
   logic       oLCD_START;
   logic       iLCD_DONE = 1'b1;

   int n_vec = 0;
   int n_bad = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   logic prev_start = 1'b0;

   lcd_expr_writer #(.DLY_MAX(DLY_MAX), .DLY_W(18)) dut (
      .iCLK(iCLK), .iRST(iRST), .iGO(iGO), .iA(iA), .iB(iB), .iOP(iOP),
      .iRES(iRES), .oBUSY(oBUSY), .oDONE(oDONE), .oLCD_DATA(oLCD_DATA),
      .oLCD_RS(oLCD_RS), .oLCD_START(oLCD_START), .iLCD_DONE(iLCD_DONE)
   );

   always #5 iCLK = ~iCLK;

   always @(negedge iCLK) begin
      if (oLCD_START && !prev_start) start_cnt++;
      prev_start = oLCD_START;
      if (oDONE) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Runs one request. long_idx selects a byte whose WAIT is stretched to 50
   // cycles while the inputs are disturbed; abort_idx resets the DUT while
   // that byte is in WAIT.
   task automatic do_request(input logic [3:0] a, input logic [1:0] op,
                             input logic [3:0] b, input logic [7:0] res,
                             input seq_t exp, input int long_idx, input int abort_idx);
      int k;
      int s0;
      int d0;
      int lat;
      bit stable;
      iA = a; iOP = op; iB = b; iRES = res; iGO = 1'b1;
      @(negedge iCLK);
      iGO = 1'b0;
      check("busy_set", oBUSY, 1);
      s0 = start_cnt;
      d0 = done_cnt;
      for (int i = 0; i < 7; i++) begin
         k = 0;
         while (!oLCD_START && k < 200) begin
            @(negedge iCLK);
            k++;
         end
         check($sformatf("start_seen%0d", i), oLCD_START, 1);
         check($sformatf("byte%0d", i), {oLCD_RS, oLCD_DATA}, exp[i]);
         if (i == abort_idx) begin
            iRST = 1'b1;
            @(negedge iCLK);
            check("abort_start", oLCD_START, 0);
            check("abort_busy", oBUSY, 0);
            iRST = 1'b0;
            repeat (8) @(negedge iCLK);
            #1;
            check("abort_nodone", done_cnt - d0, 0);
            check("abort_idle", oLCD_START, 0);
            return;
         end
         lat = (i == long_idx) ? 50 : 2;
         stable = 1'b1;
         for (int j = 0; j < lat; j++) begin
            @(negedge iCLK);
            if (i == long_idx) begin
               iGO = ~iGO;
               iA = iA + 4'd1;
               iRES = iRES + 8'd3;
            end
            if (!oLCD_START || {oLCD_RS, oLCD_DATA} !== exp[i]) stable = 1'b0;
         end
         iGO = 1'b0;
         if (i == long_idx) check("hold_stable", stable, 1);
         iLCD_DONE = 1'b1;
         @(negedge iCLK);
         iLCD_DONE = 1'b0;
         check($sformatf("start_drop%0d", i), oLCD_START, 0);
         k = 0;
         if (i < 6) begin
            while (!oLCD_START && k < 200) begin
               @(negedge iCLK);
               k++;
            end
            // DLY_MAX+1 settle cycles plus the SEND cycle
            check($sformatf("delay%0d", i), k, DLY_MAX + 2);
         end else begin
            while (!oDONE && k < 200) begin
               @(negedge iCLK);
               k++;
            end
            check("delay_last", k, DLY_MAX + 1);
            check("busy_at_done", oBUSY, 0);
         end
      end
      @(negedge iCLK);
      #1;
      check("done_pulse_low", oDONE, 0);
      check("busy_clear", oBUSY, 0);
      check("done_count", done_cnt - d0, 1);
      check("start_count", start_cnt - s0, 7);
   endtask

   seq_t r1 = '{9'h001, 9'h133, 9'h12B, 9'h134, 9'h13D, 9'h120, 9'h137};
   seq_t r2 = '{9'h001, 9'h139, 9'h12A, 9'h139, 9'h13D, 9'h138, 9'h131};
   seq_t r3 = '{9'h001, 9'h132, 9'h12D, 9'h135, 9'h13D, 9'h145, 9'h145};
   seq_t r4 = '{9'h001, 9'h13F, 9'h12F, 9'h130, 9'h13D, 9'h131, 9'h130};

   initial begin
      repeat (2) @(negedge iCLK);
      check("rst_busy", oBUSY, 0);
      check("rst_done", oDONE, 0);
      check("rst_start", oLCD_START, 0);
      check("rst_data", oLCD_DATA, 8'h00);
      check("rst_rs", oLCD_RS, 0);
      iRST = 1'b0;
      iGO = 1'b0;
      iLCD_DONE = 1'b0;
      repeat (5) @(negedge iCLK);
      check("idle_busy", oBUSY, 0);
      check("idle_start", oLCD_START, 0);

      do_request(4'd3, 2'd0, 4'd4, 8'd7, r1, -1, -1);
      do_request(4'd9, 2'd2, 4'd9, 8'd81, r2, 3, -1);
      do_request(4'd2, 2'd1, 4'd5, 8'hFD, r3, -1, -1);
      do_request(4'd12, 2'd3, 4'd0, 8'd10, r4, -1, -1);
      do_request(4'd3, 2'd0, 4'd4, 8'd7, r1, -1, 3);
      do_request(4'd3, 2'd0, 4'd4, 8'd7, r1, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
